// File: rtl/rst_pkg.sv
// Shared encodings for the staged reset sequencer: FSM states and reset-cause codes.
// No logic; latency and backpressure are not applicable.
package rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2,
        ST_SOFT  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous level; STAGES cycles of latency.
// No backpressure. All flops clear to 0 on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged active-low reset release after stable PLL lock; re-asserts on lock loss or soft request.
// Release latency SYNC_STAGES+STRETCH edges, then STAGE_GAP per output; no backpressure.
module reset_sequencer
    import rst_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 8,
    parameter int STAGE_GAP   = 16,
    parameter int SOFT_HOLD   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_locked,
    input  logic               soft_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               all_released,
    output logic [1:0]         cause,
    output logic [7:0]         lock_loss_cnt
);

    localparam int CW = $clog2(max3(STRETCH, STAGE_GAP, SOFT_HOLD)) + 1;
    localparam int IW = $clog2(NUM_OUT) + 1;

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SOFT_LAST    = CW'(SOFT_HOLD - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_OUT - 1);

    if (NUM_OUT < 1)     begin : g_bad_num_out   $error("NUM_OUT must be >= 1");     end
    if (SYNC_STAGES < 2) begin : g_bad_sync      $error("SYNC_STAGES must be >= 2"); end
    if (STRETCH < 1)     begin : g_bad_stretch   $error("STRETCH must be >= 1");     end
    if (STAGE_GAP < 1)   begin : g_bad_gap       $error("STAGE_GAP must be >= 1");   end
    if (SOFT_HOLD < 1)   begin : g_bad_soft_hold $error("SOFT_HOLD must be >= 1");   end

    logic          w_locked;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .i_d   (pll_locked),
        .o_q   (w_locked)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_HOLD;
            r_cnt         <= '0;
            r_idx         <= '0;
            rst_out_n     <= '0;
            all_released  <= 1'b0;
            cause         <= CAUSE_EXT;
            lock_loss_cnt <= '0;
        end else if (r_state != ST_HOLD && !w_locked) begin
            // Lock loss outranks everything, including a same-cycle soft request.
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
            rst_out_n    <= '0;
            all_released <= 1'b0;
            cause        <= CAUSE_LOCK;
            if (lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (!w_locked) begin
                        r_cnt <= '0;
                    end else if (r_cnt == STRETCH_LAST) begin
                        r_cnt     <= '0;
                        r_idx     <= IW'(1);
                        rst_out_n <= NUM_OUT'(1);
                        if (NUM_OUT == 1) begin
                            r_state      <= ST_RUN;
                            all_released <= 1'b1;
                        end else begin
                            r_state <= ST_STAGE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_STAGE, ST_RUN: begin
                    if (soft_req) begin
                        r_state      <= ST_SOFT;
                        r_cnt        <= '0;
                        rst_out_n    <= '0;
                        all_released <= 1'b0;
                        cause        <= CAUSE_SOFT;
                    end else if (r_state == ST_STAGE) begin
                        if (r_cnt == GAP_LAST) begin
                            r_cnt     <= '0;
                            r_idx     <= r_idx + IW'(1);
                            rst_out_n <= (rst_out_n << 1) | NUM_OUT'(1);
                            if (r_idx == LAST_IDX) begin
                                r_state      <= ST_RUN;
                                all_released <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_SOFT: begin
                    if (r_cnt == SOFT_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NUM_OUT     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int STRETCH     = 8;
    localparam int STAGE_GAP   = 16;
    localparam int SOFT_HOLD   = 16;

    logic               clk        = 1'b0;
    logic               resetn     = 1'b1;
    logic               pll_locked = 1'b0;
    logic               soft_req   = 1'b0;
    logic [NUM_OUT-1:0] rst_out_n;
    logic               all_released;
    logic [1:0]         cause;
    logic [7:0]         lock_loss_cnt;

    reset_sequencer #(
        .NUM_OUT     (NUM_OUT),
        .SYNC_STAGES (SYNC_STAGES),
        .STRETCH     (STRETCH),
        .STAGE_GAP   (STAGE_GAP),
        .SOFT_HOLD   (SOFT_HOLD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_locked    (pll_locked),
        .soft_req      (soft_req),
        .rst_out_n     (rst_out_n),
        .all_released  (all_released),
        .cause         (cause),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase + timestamps; release count derived arithmetically.
    typedef struct {
        int rst;
        int all;
        int cause;
        int llc;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   m_hist[$];
    int   m_mode  = 0;   // 0 waiting for lock, 1 releasing/running, 2 soft hold
    int   m_run   = 0;
    int   m_t0    = 0;
    int   m_ts    = 0;
    int   m_edge  = 0;
    int   m_llc   = 0;
    int   m_cause = 0;
    int   m_ls    = 0;
    int   m_k     = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode  = 0;
            m_run   = 0;
            m_edge  = 0;
            m_llc   = 0;
            m_cause = 0;
            m_hist.delete();
        end else begin
            m_ls = (m_hist.size() >= SYNC_STAGES) ? m_hist[m_hist.size() - SYNC_STAGES] : 0;
            m_hist.push_back(int'(pll_locked));
            if (m_hist.size() > SYNC_STAGES + 2) void'(m_hist.pop_front());
            m_edge++;
            if (m_mode != 0 && m_ls == 0) begin
                m_mode  = 0;
                m_run   = 0;
                m_cause = 1;
                m_llc++;
            end else if (m_mode == 0) begin
                m_run = (m_ls != 0) ? m_run + 1 : 0;
                if (m_run == STRETCH) begin
                    m_mode = 1;
                    m_t0   = m_edge;
                end
            end else if (m_mode == 1) begin
                if (soft_req) begin
                    m_mode  = 2;
                    m_ts    = m_edge;
                    m_cause = 2;
                end
            end else if (m_edge - m_ts == SOFT_HOLD) begin
                m_mode = 0;
                m_run  = 0;
            end
            m_k = (m_mode == 1) ? 1 + (m_edge - m_t0) / STAGE_GAP : 0;
            if (m_k > NUM_OUT) m_k = NUM_OUT;
            sb_q.push_back('{rst: (1 << m_k) - 1, all: int'(m_k == NUM_OUT),
                             cause: m_cause, llc: (m_llc > 255) ? 255 : m_llc});
        end
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            chk("rst_out_n", int'(rst_out_n), m_e.rst);
            chk("all_released", int'(all_released), m_e.all);
            chk("cause", int'(cause), m_e.cause);
            chk("lock_loss_cnt", int'(lock_loss_cnt), m_e.llc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_mask(input logic [NUM_OUT-1:0] mask, input string name);
        int n;
        n = 0;
        while ((rst_out_n & mask) != mask && n < 400) begin
            tick();
            n++;
        end
        if ((rst_out_n & mask) != mask) chk({name, "_timeout"}, int'(rst_out_n), int'(mask));
    endtask

    int rel[NUM_OUT];
    int all_e;
    int n;
    int s_edge;
    int low_left;

    initial begin
        #1 resetn = 1'b0;
        pll_locked = 1'b1;
        repeat (3) tick();
        chk("reset_rst_out_n", int'(rst_out_n), 0);
        chk("reset_all_released", int'(all_released), 0);
        resetn = 1'b1;

        // Power-up release timeline.
        for (int i = 0; i < NUM_OUT; i++) rel[i] = 0;
        all_e = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int i = 0; i < NUM_OUT; i++)
                if (rst_out_n[i] && rel[i] == 0) rel[i] = m_edge;
            if (all_released && all_e == 0) all_e = m_edge;
        end
        for (int i = 0; i < NUM_OUT; i++)
            chk($sformatf("release_edge_%0d", i), rel[i], 10 + 16 * i);
        chk("all_released_edge", all_e, 58);
        chk("powerup_cause", int'(cause), 0);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        n = 0;
        while (rst_out_n != '0 && n < 10) begin
            tick();
            n++;
        end
        chk("lockloss_latency", n, SYNC_STAGES + 1);
        chk("lockloss_cause", int'(cause), 1);
        chk("lockloss_cnt", int'(lock_loss_cnt), 1);
        pll_locked = 1'b1;
        wait_mask('1, "relock");

        // Soft request in RUN.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        s_edge = m_edge;
        chk("soft_immediate", int'(rst_out_n), 0);
        chk("soft_cause", int'(cause), 2);
        n = 0;
        while (!all_released && n < 200) begin
            tick();
            n++;
        end
        chk("soft_total_edges", m_edge - s_edge, SOFT_HOLD + STRETCH + (NUM_OUT - 1) * STAGE_GAP);

        // Soft request and lock loss on the same edge in STAGE.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        wait_mask(4'b0011, "stage_0011");
        pll_locked = 1'b0;
        tick();
        tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        chk("both_rst", int'(rst_out_n), 0);
        chk("both_cause", int'(cause), 1);
        chk("both_cnt", int'(lock_loss_cnt), 2);
        pll_locked = 1'b1;

        // Asynchronous reset mid-STAGE.
        wait_mask(4'b0011, "stage_before_reset");
        resetn = 1'b0;
        #1;
        chk("async_rst_out_n", int'(rst_out_n), 0);
        chk("async_all_released", int'(all_released), 0);
        chk("async_cause", int'(cause), 0);
        chk("async_cnt", int'(lock_loss_cnt), 0);
        tick();
        resetn = 1'b1;

        // Three-cycle lock glitch while qualifying in HOLD.
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        n = 0;
        while (!rst_out_n[0] && n < 100) begin
            tick();
            n++;
        end
        chk("glitch_release_edge", m_edge, 18);
        chk("glitch_cnt", int'(lock_loss_cnt), 0);

        // Randomised soft requests and lock glitches.
        low_left = 0;
        for (int c = 0; c < 3000; c++) begin
            soft_req = ($urandom_range(0, 119) == 0);
            if (low_left > 0) begin
                low_left--;
                if (low_left == 0) pll_locked = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                pll_locked = 1'b0;
                low_left   = $urandom_range(1, 6);
            end
            tick();
        end
        soft_req   = 1'b0;
        pll_locked = 1'b1;

        // Drive the lock-loss counter into saturation.
        for (int it = 0; it < 300; it++) begin
            wait_mask(4'b0001, "sat_release");
            pll_locked = 1'b0;
            repeat (3) tick();
            pll_locked = 1'b1;
        end
        tick();
        chk("llc_saturated", int'(lock_loss_cnt), 255);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
